// File: rtl/comp_data_checker.sv
// Pairs compare-data updates from two lockstep cores, compares them and reports
// match/mismatch counts, divergence and missing-partner timeouts over Avalon-MM.
module comp_data_checker #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_stb,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_stb,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        WAIT_A = 2'd2
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic              cmp_go;
    logic [DATA_W-1:0] match_cnt;
    logic [DATA_W-1:0] mismatch_cnt;
    logic              mismatch_sticky;
    logic              timeout_sticky;
    logic              enable;
    logic              irq_en;

    logic wr;
    logic busy;
    logic partner_stb;
    logic own_stb;
    logic timeout_hit;
    logic cmp_fire;
    logic is_match;
    logic unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign busy         = (state != IDLE);
    assign partner_stb  = (state == WAIT_B) ? b_stb : a_stb;
    assign own_stb      = (state == WAIT_B) ? a_stb : b_stb;
    assign timeout_hit  = enable & busy & ~a_stb & ~b_stb & (timer == TIMER_LAST);
    assign cmp_fire     = cmp_go & enable;
    assign is_match     = (cap_a == cap_b);
    assign unused_wdata = ^writedata[31:2];

    // Pairing FSM, capture registers and wait timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            cmp_go <= 1'b0;
        end else begin
            cmp_go <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                if (a_stb) cap_a <= a_data;
                if (b_stb) cap_b <= b_data;
                case (state)
                    IDLE: begin
                        timer <= '0;
                        if (a_stb && b_stb) cmp_go <= 1'b1;
                        else if (a_stb)     state  <= WAIT_B;
                        else if (b_stb)     state  <= WAIT_A;
                    end
                    WAIT_A, WAIT_B: begin
                        if (partner_stb) begin
                            cmp_go <= 1'b1;
                            state  <= IDLE;
                            timer  <= '0;
                        end else if (own_stb) begin
                            timer <= '0;
                        end else if (timer == TIMER_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    // Result counters, sticky flags, control and irq; clears lose to sets, win over increments
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_cnt       <= '0;
            mismatch_cnt    <= '0;
            mismatch_sticky <= 1'b0;
            timeout_sticky  <= 1'b0;
            enable          <= 1'b1;
            irq_en          <= 1'b0;
            irq             <= 1'b0;
        end else begin
            if (wr && address == 2'd1)
                match_cnt <= '0;
            else if (cmp_fire && is_match && match_cnt != CNT_MAX)
                match_cnt <= match_cnt + DATA_W'(1);

            if (wr && address == 2'd2)
                mismatch_cnt <= '0;
            else if (cmp_fire && !is_match && mismatch_cnt != CNT_MAX)
                mismatch_cnt <= mismatch_cnt + DATA_W'(1);

            if (cmp_fire && !is_match)
                mismatch_sticky <= 1'b1;
            else if (wr && address == 2'd0 && writedata[0])
                mismatch_sticky <= 1'b0;

            if (timeout_hit)
                timeout_sticky <= 1'b1;
            else if (wr && address == 2'd0 && writedata[1])
                timeout_sticky <= 1'b0;

            if (wr && address == 2'd3) begin
                enable <= writedata[0];
                irq_en <= writedata[1];
            end

            irq <= irq_en & (mismatch_sticky | timeout_sticky);
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata = {26'd0, 2'(state), 1'b0, busy, timeout_sticky, mismatch_sticky};
                2'd1:    readdata = 32'(match_cnt);
                2'd2:    readdata = 32'(mismatch_cnt);
                default: readdata = {30'd0, irq_en, enable};
            endcase
        end
    end

endmodule

// File: tb/tb_comp_data_checker.sv
// Directed bench: main instance (32-bit, TIMEOUT=16) plus a 4-bit instance for saturation.
module tb_comp_data_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] a_data, b_data;
    logic        a_stb, b_stb;
    logic [3:0]  s_a_data, s_b_data;
    logic        s_a_stb, s_b_stb;
    logic [1:0]  address;
    logic        cs, s_cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata, s_readdata;
    logic        irq, s_irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd;
    int busy_cycles;

    always #5 clk = ~clk;

    comp_data_checker #(.DATA_W(32), .TIMEOUT(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .a_data(a_data), .a_stb(a_stb), .b_data(b_data), .b_stb(b_stb),
        .address(address), .chipselect(cs), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    comp_data_checker #(.DATA_W(4), .TIMEOUT(16)) u_sat (
        .clk(clk), .reset_n(reset_n),
        .a_data(s_a_data), .a_stb(s_a_stb), .b_data(s_b_data), .b_stb(s_b_stb),
        .address(address), .chipselect(s_cs), .write_n(write_n), .writedata(writedata),
        .readdata(s_readdata), .irq(s_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic sat, input logic [1:0] addr, input logic [31:0] data);
        address = addr; writedata = data; write_n = 1'b0;
        cs = ~sat; s_cs = sat;
        tick();
        cs = 1'b0; s_cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic sat, input logic [1:0] addr, output logic [31:0] data);
        address = addr; write_n = 1'b1;
        cs = ~sat; s_cs = sat;
        #1;
        data = sat ? s_readdata : readdata;
        cs = 1'b0; s_cs = 1'b0;
    endtask

    task automatic strobe(input logic sa, input logic [31:0] va, input logic sb, input logic [31:0] vb);
        a_stb = sa; a_data = va; b_stb = sb; b_data = vb;
        tick();
        a_stb = 1'b0; b_stb = 1'b0;
    endtask

    task automatic s_strobe(input logic [3:0] va, input logic [3:0] vb);
        s_a_stb = 1'b1; s_a_data = va; s_b_stb = 1'b1; s_b_data = vb;
        tick();
        s_a_stb = 1'b0; s_b_stb = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (readdata !== 32'h0) begin n_errors++; $display("FAIL reset_nocs_read: got %h expected %h", readdata, 32'h0); end
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_match: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd2, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_mismatch: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd3, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL reset_ctrl: got %h expected %h", rd, 32'h1); end
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_simultaneous_match();
        strobe(1'b1, 32'h12345678, 1'b1, 32'h12345678);
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL match_latency_early: got %h expected %h", rd, 32'h0); end
        tick();
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL match_count: got %h expected %h", rd, 32'h1); end
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL match_status: got %h expected %h", rd, 32'h0); end
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL match_irq: got %b expected 0", irq); end
        bus_write(1'b0, 2'd1, 32'h0);
    endtask

    task automatic test_mismatch_irq();
        bus_write(1'b0, 2'd3, 32'h3);
        strobe(1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h14) begin n_errors++; $display("FAIL wait_b_status: got %h expected %h", rd, 32'h14); end
        repeat (4) tick();
        strobe(1'b0, 32'h0, 1'b1, 32'hDEADBEEE);
        tick();
        bus_read(1'b0, 2'd2, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL mismatch_count: got %h expected %h", rd, 32'h1); end
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL mismatch_status: got %h expected %h", rd, 32'h1); end
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_latency_early: got %b expected 0", irq); end
        tick(); n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
        bus_write(1'b0, 2'd0, 32'h1);
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL w1c_status: got %h expected %h", rd, 32'h0); end
        tick(); n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_deassert: got %b expected 0", irq); end
        bus_write(1'b0, 2'd2, 32'h0);
        bus_write(1'b0, 2'd3, 32'h1);
    endtask

    task automatic test_timeout();
        strobe(1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            bus_read(1'b0, 2'd0, rd);
            if (rd[2] !== 1'b1) break;
            busy_cycles++;
            tick();
        end
        n_checks++;
        if (busy_cycles != 16) begin n_errors++; $display("FAIL timeout_busy_cycles: got %0d expected %0d", busy_cycles, 16); end
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h2) begin n_errors++; $display("FAIL timeout_status: got %h expected %h", rd, 32'h2); end
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL timeout_match: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd2, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL timeout_mismatch: got %h expected %h", rd, 32'h0); end
        bus_write(1'b0, 2'd0, 32'h2);
        // partner strobe on the last timer cycle still pairs
        strobe(1'b1, 32'h77, 1'b0, 32'h0);
        repeat (15) tick();
        strobe(1'b0, 32'h0, 1'b1, 32'h77);
        tick();
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL edge_partner_status: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL edge_partner_match: got %h expected %h", rd, 32'h1); end
        bus_write(1'b0, 2'd1, 32'h0);
    endtask

    task automatic test_recapture();
        strobe(1'b1, 32'h1, 1'b0, 32'h0);
        repeat (10) tick();
        strobe(1'b1, 32'h2, 1'b0, 32'h0);
        repeat (15) tick();
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h14) begin n_errors++; $display("FAIL recapture_timer_restart: got %h expected %h", rd, 32'h14); end
        strobe(1'b0, 32'h0, 1'b1, 32'h2);
        tick();
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL recapture_match: got %h expected %h", rd, 32'h1); end
        bus_read(1'b0, 2'd2, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL recapture_mismatch: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL recapture_status: got %h expected %h", rd, 32'h0); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 15; i++) s_strobe(4'h1, 4'h2);
        tick();
        bus_read(1'b1, 2'd2, rd); n_checks++;
        if (rd !== 32'hF) begin n_errors++; $display("FAIL sat_reach_max: got %h expected %h", rd, 32'hF); end
        s_strobe(4'h3, 4'h4);
        tick();
        bus_read(1'b1, 2'd2, rd); n_checks++;
        if (rd !== 32'hF) begin n_errors++; $display("FAIL sat_hold_max: got %h expected %h", rd, 32'hF); end
        s_strobe(4'h5, 4'h6);
        bus_write(1'b1, 2'd2, 32'h0);
        bus_read(1'b1, 2'd2, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL clear_beats_incr: got %h expected %h", rd, 32'h0); end
        tick();
        bus_read(1'b1, 2'd2, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL clear_stays: got %h expected %h", rd, 32'h0); end
        bus_write(1'b1, 2'd0, 32'h1);
        bus_read(1'b1, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL sat_w1c: got %h expected %h", rd, 32'h0); end
        s_strobe(4'h7, 4'h8);
        bus_write(1'b1, 2'd0, 32'h1);
        bus_read(1'b1, 2'd0, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL set_beats_w1c: got %h expected %h", rd, 32'h1); end
    endtask

    task automatic test_disable_and_reset();
        bus_write(1'b0, 2'd3, 32'h0);
        strobe(1'b1, 32'h5, 1'b1, 32'h5);
        strobe(1'b1, 32'h6, 1'b0, 32'h0);
        tick();
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL disabled_match: got %h expected %h", rd, 32'h1); end
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL disabled_status: got %h expected %h", rd, 32'h0); end
        bus_write(1'b0, 2'd3, 32'h3);
        strobe(1'b0, 32'h0, 1'b1, 32'h9);
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h24) begin n_errors++; $display("FAIL wait_a_status: got %h expected %h", rd, 32'h24); end
        #2 reset_n = 1'b0;
        #1;
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL midwait_reset_status: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd1, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL midwait_reset_match: got %h expected %h", rd, 32'h0); end
        bus_read(1'b0, 2'd3, rd); n_checks++;
        if (rd !== 32'h1) begin n_errors++; $display("FAIL midwait_reset_ctrl: got %h expected %h", rd, 32'h1); end
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL midwait_reset_irq: got %b expected 0", irq); end
        tick();
        reset_n = 1'b1;
        tick();
        bus_read(1'b0, 2'd0, rd); n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL post_reset_status: got %h expected %h", rd, 32'h0); end
    endtask

    initial begin
        reset_n = 1'b0;
        a_data = '0; b_data = '0; a_stb = 1'b0; b_stb = 1'b0;
        s_a_data = '0; s_b_data = '0; s_a_stb = 1'b0; s_b_stb = 1'b0;
        address = '0; cs = 1'b0; s_cs = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_simultaneous_match();
        test_mismatch_irq();
        test_timeout();
        test_recapture();
        test_saturation();
        test_disable_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
